spi_loopback_tester: RTL and testbench
======================================

Name: spi_loopback_tester

Overview:
- Parametrised self-test sequencer for SPI master/slave loopback.
- Periodically runs framed transfers between an spi_master and an spi_slave wired back-to-back, generating per-transfer data patterns and comparing both directions.
- Optionally sweeps all four CPOL/CPHA modes.
- Counts passes and errors, detects hung transfers, and drives active-low status LEDs.
- Sits at the top level between the PLL-clocked control domain and the two SPI instances.

Parameters:
- WIDTH, 8: SPI word width in bits.
- INTERVAL, 67108864: clk cycles idled between transfers (≥2).
- BURST, 16: transfers per mode before advancing mode.
- TIMEOUT, 1024: max clk cycles in WAIT_DONE before abort.
- MODE_SWEEP, 1: 1 = step mode 0→1→2→3→0; 0 = fixed mode 0.
- MASTER_SEED, 8'h5A: first master tx word (width WIDTH).
- SLAVE_SEED, 8'hC3: first slave tx word (width WIDTH).
- BAUD_DIV, 1: value driven on baud_div.

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  asynchronous active-low reset.
- enable  in  1  permits new transfers; sampled only in IDLE.
- clear  in  1  synchronous pulse; zeroes counters, sticky flags, leds; patterns back to seeds.
- master_done  in  1  one-cycle done pulse from spi_master.
- master_rx  in  WIDTH  word received by master.
- slave_rx  in  WIDTH  word received by slave.
- cs  out  1  slave select, active low.
- start  out  1  one-cycle start pulse to spi_master.
- master_tx  out  WIDTH  word master sends.
- slave_tx  out  WIDTH  word slave returns.
- cpol  out  1  current clock polarity.
- cpha  out  1  current clock phase.
- baud_div  out  16  constant BAUD_DIV.
- pass_count  out  16  saturating count of fully-correct transfers.
- err_count  out  16  saturating count of failed or timed-out transfers.
- timeout_seen  out  1  sticky; set on any timeout.
- led  out  2  active low. [0] = last master compare OK; [1] = last slave compare OK.

Behaviour:
- Reset values:
  - cs=1, start=0, master_tx=MASTER_SEED, slave_tx=SLAVE_SEED, mode=0 (cpol=0, cpha=0).
  - Both counters 0, timeout_seen=0, led=2'b11, state IDLE, interval counter 0.
- Mode encoding: cpol=mode[1], cpha=mode[0].
- FSM states: IDLE, CS_LOW, START, WAIT_DONE, SETTLE, CHECK.
- IDLE:
  - Interval counter increments each cycle, saturating at INTERVAL-1.
  - When it equals INTERVAL-1 and enable=1: clear the counter, cs<=0, go CS_LOW.
  - While enable=0, the counter holds at INTERVAL-1, so the transfer begins the first cycle enable is high.
- CS_LOW: start<=1, go START. cs is low for exactly one cycle before start.
- START: start<=0, clear timeout counter, go WAIT_DONE. start is high exactly one cycle.
- WAIT_DONE:
  - On master_done: cs<=1, go SETTLE.
  - Otherwise increment the timeout counter. If it reaches TIMEOUT-1: cs<=1, err_count+1, timeout_seen<=1, led<=2'b11, advance patterns, go IDLE.
- SETTLE: wait 2 cycles (cross-domain settling of slave_rx), then go CHECK.
- CHECK (one cycle):
  - led[0] <= (master_rx != slave_tx); led[1] <= (slave_rx != master_tx).
  - If both match: pass_count+1, else err_count+1.
  - Advance patterns and the burst counter; go IDLE.
- Pattern advance: p_next = rotl1(p) + 1 mod 2^WIDTH, applied to master_tx and slave_tx independently. Example: 5A→B5, C3→88.
- Burst/mode: burst counter counts completed (checked or timed-out) transfers. On reaching BURST, reset it to 0 and, if MODE_SWEEP, increment mode with wrap 3→0.
- Mode and pattern outputs change only in CHECK or on timeout, never while cs=0.
- Counters saturate at 16'hFFFF and do not wrap.
- master_done outside WAIT_DONE is ignored.
- clear:
  - In IDLE: takes effect in that cycle.
  - In any other state: takes effect at the next return to IDLE; the in-flight transfer completes normally but its result is discarded.
- Reset is asynchronous and may occur mid-transfer; it forces reset values immediately (cs high, start low).

Test Plan:
- Reset pulse mid-WAIT_DONE → cs=1, start=0, led=11, counters 0 within the asserted cycle. (INTERVAL=8 for all scenarios.)
- Ideal loopback model, enable=1 → cs falls one cycle before the single-cycle start. First transfer: master_tx=5A, slave_tx=C3. After CHECK: pass_count=1, led=00, master_tx=B5, slave_tx=88.
- Corrupt slave_rx (flip bit0) on transfer 1 → err_count=1, pass_count=0, led=2'b10. Next correct transfer restores led=00.
- master_done withheld, TIMEOUT=16 → cs rises 16 cycles after start, err_count=1, timeout_seen=1, led=11, state back in IDLE.
- BURST=2, MODE_SWEEP=1, 8 good transfers → (cpol,cpha) sequence 00,00,01,01,10,10,11,11, then wraps to 00. With MODE_SWEEP=0, stays 00.
- Force pass_count to FFFF via long run or preload, one more good transfer → stays FFFF. clear pulse in IDLE → counters 0, led=11, master_tx=5A.

Source files
------------

// File: rtl/spi_loopback_tester.sv
// spi_loopback_tester
//   Self-test sequencer for an spi_master / spi_slave pair wired back to back.
//   It runs one framed transfer every INTERVAL cycles. Each transfer uses fresh
//   data patterns, and the sequencer checks both directions of the loopback.
//   It can sweep the four CPOL/CPHA modes. It counts passes and errors, catches
//   hung transfers, and drives active-low status LEDs.
//
// Ports
//   clk          system clock (PLL output)
//   rst          asynchronous reset, active low
//   enable       allows new transfers; only looked at while idle
//   clear        one-cycle pulse: zero counters, flags and leds, reload seeds
//   master_done  one-cycle completion pulse from spi_master
//   master_rx    word received by the master
//   slave_rx     word received by the slave
//   cs           slave select, active low
//   start        one-cycle start pulse to spi_master
//   master_tx    word the master sends
//   slave_tx     word the slave returns
//   cpol, cpha   current SPI mode (cpol = mode[1], cpha = mode[0])
//   baud_div     constant BAUD_DIV for the master
//   pass_count   saturating count of fully correct transfers
//   err_count    saturating count of failed or timed-out transfers
//   timeout_seen sticky flag, set by any timeout
//   led          active low: [0] last master compare ok, [1] last slave compare ok
//   dbg_state    current FSM state, for observation only
//
// Handshake: start is a one-cycle request, and cs is already low one cycle
// before it. master_done is a one-cycle completion. It is accepted only in
// WAIT_DONE and ignored in every other state.
module spi_loopback_tester #(
   parameter int unsigned       WIDTH       = 8,
   parameter int unsigned       INTERVAL    = 67108864,
   parameter int unsigned       BURST       = 16,
   parameter int unsigned       TIMEOUT     = 1024,
   parameter bit                MODE_SWEEP  = 1'b1,
   parameter logic [WIDTH-1:0]  MASTER_SEED = 'h5A,
   parameter logic [WIDTH-1:0]  SLAVE_SEED  = 'hC3,
   parameter int unsigned       BAUD_DIV    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic             master_done,
   input  logic [WIDTH-1:0] master_rx,
   input  logic [WIDTH-1:0] slave_rx,
   output logic             cs,
   output logic             start,
   output logic [WIDTH-1:0] master_tx,
   output logic [WIDTH-1:0] slave_tx,
   output logic             cpol,
   output logic             cpha,
   output logic [15:0]      baud_div,
   output logic [15:0]      pass_count,
   output logic [15:0]      err_count,
   output logic             timeout_seen,
   output logic [1:0]       led,
   output logic [2:0]       dbg_state
);

   localparam int IW = $clog2(INTERVAL);
   localparam int TW = $clog2(TIMEOUT);
   localparam int BW = $clog2(BURST + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CS_LOW    = 3'd1,
      START     = 3'd2,
      WAIT_DONE = 3'd3,
      SETTLE    = 3'd4,
      CHECK     = 3'd5
   } state_t;

   state_t          state;
   logic [IW-1:0]   icnt;
   logic [TW-1:0]   tcnt;
   logic [BW-1:0]   burst;
   logic [1:0]      mode;
   logic            scnt;
   logic            clear_pend;

   logic [TW-1:0]   tcnt_inc;
   logic [BW-1:0]   burst_inc;
   logic            timeout_hit;
   logic            xfer_end;
   logic            do_clear;

   function automatic logic [WIDTH-1:0] next_pat(input logic [WIDTH-1:0] p);
      return {p[WIDTH-2:0], p[WIDTH-1]} + WIDTH'(1);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign cpol      = mode[1];
   assign cpha      = mode[0];
   assign baud_div  = 16'(BAUD_DIV);
   assign dbg_state = state;

   always_comb begin
      tcnt_inc    = tcnt + TW'(1);
      burst_inc   = burst + BW'(1);
      timeout_hit = (state == WAIT_DONE) && !master_done &&
                    (tcnt_inc == TW'(TIMEOUT - 1));
      xfer_end    = (state == CHECK) || timeout_hit;
      // A clear that arrives mid-transfer waits for the return to IDLE.
      // It then replaces that transfer's result.
      do_clear    = ((state == IDLE) && clear) ||
                    (xfer_end && (clear || clear_pend));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         icnt         <= '0;
         tcnt         <= '0;
         burst        <= '0;
         mode         <= 2'd0;
         scnt         <= 1'b0;
         clear_pend   <= 1'b0;
         cs           <= 1'b1;
         start        <= 1'b0;
         master_tx    <= MASTER_SEED;
         slave_tx     <= SLAVE_SEED;
         pass_count   <= 16'd0;
         err_count    <= 16'd0;
         timeout_seen <= 1'b0;
         led          <= 2'b11;
      end else begin
         case (state)
            IDLE: begin
               // The counter parks at INTERVAL-1, so the next transfer starts
               // in the first cycle that enable is high.
               if (icnt == IW'(INTERVAL - 1)) begin
                  if (enable) begin
                     icnt  <= '0;
                     cs    <= 1'b0;
                     state <= CS_LOW;
                  end
               end else begin
                  icnt <= icnt + IW'(1);
               end
            end
            CS_LOW: begin
               start <= 1'b1;
               state <= START;
            end
            START: begin
               start <= 1'b0;
               tcnt  <= '0;
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (master_done) begin
                  cs    <= 1'b1;
                  scnt  <= 1'b0;
                  state <= SETTLE;
               end else if (timeout_hit) begin
                  cs    <= 1'b1;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt_inc;
               end
            end
            SETTLE: begin
               // Two cycles so that slave_rx has crossed from the SPI domain.
               if (scnt) state <= CHECK;
               else      scnt  <= 1'b1;
            end
            CHECK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cs    <= 1'b1;
               start <= 1'b0;
            end
         endcase

         if (do_clear) begin
            pass_count   <= 16'd0;
            err_count    <= 16'd0;
            timeout_seen <= 1'b0;
            led          <= 2'b11;
            master_tx    <= MASTER_SEED;
            slave_tx     <= SLAVE_SEED;
            burst        <= '0;
            clear_pend   <= 1'b0;
         end else begin
            if (clear) clear_pend <= 1'b1;
            if (xfer_end) begin
               if (timeout_hit) begin
                  err_count    <= sat_inc(err_count);
                  timeout_seen <= 1'b1;
                  led          <= 2'b11;
               end else begin
                  led[0] <= (master_rx != slave_tx);
                  led[1] <= (slave_rx != master_tx);
                  if ((master_rx == slave_tx) && (slave_rx == master_tx))
                     pass_count <= sat_inc(pass_count);
                  else
                     err_count  <= sat_inc(err_count);
               end
               master_tx <= next_pat(master_tx);
               slave_tx  <= next_pat(slave_tx);
               if (burst_inc == BW'(BURST)) begin
                  burst <= '0;
                  if (MODE_SWEEP) mode <= mode + 2'd1;
               end else begin
                  burst <= burst_inc;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_loopback_tester.sv
// Testbench for spi_loopback_tester.
// Runs two instances with INTERVAL=8, TIMEOUT=16 and BURST=2:
//   dut   - MODE_SWEEP=1, its loopback model can be faulted
//   dut_b - MODE_SWEEP=0, its loopback model is always ideal
module tb_spi_loopback_tester;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CS_LOW = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_CHECK  = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b1;
   logic        clear = 1'b0;

   logic        a_done = 1'b0;
   logic [7:0]  a_mrx = 8'h00, a_srx = 8'h00;
   logic        a_cs, a_start, a_cpol, a_cpha, a_to;
   logic [7:0]  a_mtx, a_stx;
   logic [15:0] a_baud, a_pass, a_err;
   logic [1:0]  a_led;
   logic [2:0]  a_dbg;

   logic        b_done = 1'b0;
   logic [7:0]  b_mrx = 8'h00, b_srx = 8'h00;
   logic        b_cs, b_start, b_cpol, b_cpha, b_to;
   logic [7:0]  b_mtx, b_stx;
   logic [15:0] b_baud, b_pass, b_err;
   logic [1:0]  b_led;
   logic [2:0]  b_dbg;

   logic        withhold = 1'b1;
   logic        corrupt = 1'b0;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   spi_loopback_tester #(.WIDTH(8), .INTERVAL(8), .BURST(2), .TIMEOUT(16),
      .MODE_SWEEP(1'b1), .MASTER_SEED(8'h5A), .SLAVE_SEED(8'hC3), .BAUD_DIV(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .master_done(a_done), .master_rx(a_mrx), .slave_rx(a_srx),
      .cs(a_cs), .start(a_start), .master_tx(a_mtx), .slave_tx(a_stx),
      .cpol(a_cpol), .cpha(a_cpha), .baud_div(a_baud), .pass_count(a_pass),
      .err_count(a_err), .timeout_seen(a_to), .led(a_led), .dbg_state(a_dbg));

   spi_loopback_tester #(.WIDTH(8), .INTERVAL(8), .BURST(2), .TIMEOUT(16),
      .MODE_SWEEP(1'b0), .MASTER_SEED(8'h5A), .SLAVE_SEED(8'hC3), .BAUD_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .clear(1'b0),
      .master_done(b_done), .master_rx(b_mrx), .slave_rx(b_srx),
      .cs(b_cs), .start(b_start), .master_tx(b_mtx), .slave_tx(b_stx),
      .cpol(b_cpol), .cpha(b_cpha), .baud_div(b_baud), .pass_count(b_pass),
      .err_count(b_err), .timeout_seen(b_to), .led(b_led), .dbg_state(b_dbg));

   // Loopback model for dut. Two cycles after start it returns each side's
   // tx word to the other side. It can withhold done or flip slave_rx bit 0.
   initial begin
      forever begin
         @(negedge clk);
         if (a_start === 1'b1 && !withhold) begin
            repeat (2) @(negedge clk);
            a_mrx  = a_stx;
            a_srx  = a_mtx ^ {7'b0, corrupt};
            a_done = 1'b1;
            @(negedge clk);
            a_done = 1'b0;
         end
      end
   end

   // Ideal loopback model for dut_b.
   initial begin
      forever begin
         @(negedge clk);
         if (b_start === 1'b1) begin
            repeat (2) @(negedge clk);
            b_mrx  = b_stx;
            b_srx  = b_mtx;
            b_done = 1'b1;
            @(negedge clk);
            b_done = 1'b0;
         end
      end
   end

   // Bounded wait until dut reaches state st, sampled on negedges.
   task automatic wait_state(input logic [2:0] st, input string tag);
      int cyc;
      cyc = 0;
      while (a_dbg !== st && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (a_dbg !== st) begin
         n_total++;
         $display("FAIL %s_wait: state=%0d never reached %0d", tag, a_dbg, st);
      end
   endtask

   // Wait for the CHECK cycle of the running transfer, then one more negedge
   // so that its results are registered.
   task automatic wait_xfer(input string tag);
      wait_state(S_CHECK, tag);
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++; if (a_cs !== 1'b1) $display("FAIL rst_cs: got %b want 1", a_cs); else n_pass++;
      n_total++; if (a_start !== 1'b0) $display("FAIL rst_start: got %b want 0", a_start); else n_pass++;
      n_total++; if (a_mtx !== 8'h5A) $display("FAIL rst_mtx: got %h want 5a", a_mtx); else n_pass++;
      n_total++; if (a_stx !== 8'hC3) $display("FAIL rst_stx: got %h want c3", a_stx); else n_pass++;
      n_total++; if ({a_cpol, a_cpha} !== 2'b00) $display("FAIL rst_mode: got %b%b want 00", a_cpol, a_cpha); else n_pass++;
      n_total++; if (a_pass !== 16'd0 || a_err !== 16'd0) $display("FAIL rst_counts: got %0d/%0d want 0/0", a_pass, a_err); else n_pass++;
      n_total++; if (a_to !== 1'b0 || a_led !== 2'b11) $display("FAIL rst_flags: got to=%b led=%b want 0/11", a_to, a_led); else n_pass++;
      n_total++; if (a_baud !== 16'd1 || a_dbg !== S_IDLE) $display("FAIL rst_baud_state: got %0d/%0d want 1/0", a_baud, a_dbg); else n_pass++;
      n_total++;
      if ({b_cs, b_start, b_mtx, b_stx, b_cpol, b_cpha, b_baud, b_pass, b_err, b_to, b_led, b_dbg}
          !== {1'b1, 1'b0, 8'h5A, 8'hC3, 2'b00, 16'd1, 16'd0, 16'd0, 1'b0, 2'b11, 3'd0})
         $display("FAIL rst_b: got cs=%b mtx=%h stx=%h pass=%0d led=%b", b_cs, b_mtx, b_stx, b_pass, b_led);
      else n_pass++;
      // Assert reset in the middle of a hung transfer.
      rst = 1'b1;
      wait_state(S_WAIT, "rst_mid");
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_total++;
      if (a_cs !== 1'b1 || a_start !== 1'b0 || a_led !== 2'b11 || a_pass !== 16'd0 || a_err !== 16'd0 || a_dbg !== S_IDLE)
         $display("FAIL rst_mid: got cs=%b start=%b led=%b pass=%0d err=%0d st=%0d", a_cs, a_start, a_led, a_pass, a_err, a_dbg);
      else n_pass++;
      @(negedge clk);
      withhold = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_first_transfer();
      wait_state(S_CS_LOW, "first_cs");
      n_total++; if (a_cs !== 1'b0 || a_start !== 1'b0) $display("FAIL first_cs_before_start: got cs=%b start=%b want 0/0", a_cs, a_start); else n_pass++;
      n_total++; if (a_mtx !== 8'h5A || a_stx !== 8'hC3) $display("FAIL first_tx: got %h/%h want 5a/c3", a_mtx, a_stx); else n_pass++;
      @(negedge clk);
      n_total++; if (a_cs !== 1'b0 || a_start !== 1'b1) $display("FAIL first_start_hi: got cs=%b start=%b want 0/1", a_cs, a_start); else n_pass++;
      @(negedge clk);
      n_total++; if (a_start !== 1'b0) $display("FAIL first_start_lo: got %b want 0", a_start); else n_pass++;
      wait_xfer("first");
      n_total++; if (a_pass !== 16'd1 || a_err !== 16'd0) $display("FAIL first_counts: got %0d/%0d want 1/0", a_pass, a_err); else n_pass++;
      n_total++; if (a_led !== 2'b00 || a_cs !== 1'b1) $display("FAIL first_led_cs: got led=%b cs=%b want 00/1", a_led, a_cs); else n_pass++;
      n_total++; if (a_mtx !== 8'hB5 || a_stx !== 8'h88) $display("FAIL first_next_pat: got %h/%h want b5/88", a_mtx, a_stx); else n_pass++;
   endtask

   task automatic test_corrupt();
      wait_state(S_IDLE, "corrupt_idle");
      clear = 1'b1;
      corrupt = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      wait_xfer("corrupt");
      corrupt = 1'b0;
      n_total++; if (a_pass !== 16'd0 || a_err !== 16'd1) $display("FAIL corrupt_counts: got %0d/%0d want 0/1", a_pass, a_err); else n_pass++;
      n_total++; if (a_led !== 2'b10) $display("FAIL corrupt_led: got %b want 10", a_led); else n_pass++;
      wait_xfer("recover");
      n_total++; if (a_pass !== 16'd1 || a_err !== 16'd1 || a_led !== 2'b00) $display("FAIL recover: got pass=%0d err=%0d led=%b want 1/1/00", a_pass, a_err, a_led); else n_pass++;
      // Seeds, then two advances: 5A->B5->6C and C3->88->12.
      n_total++; if (a_mtx !== 8'h6C || a_stx !== 8'h12) $display("FAIL recover_pat: got %h/%h want 6c/12", a_mtx, a_stx); else n_pass++;
   endtask

   task automatic test_timeout();
      int cyc;
      withhold = 1'b1;
      wait_state(S_START, "to_start");
      cyc = 0;
      while (a_cs !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      n_total++; if (cyc != 16) $display("FAIL to_cs_delay: got %0d cycles want 16", cyc); else n_pass++;
      n_total++; if (a_err !== 16'd2 || a_pass !== 16'd1) $display("FAIL to_counts: got err=%0d pass=%0d want 2/1", a_err, a_pass); else n_pass++;
      n_total++; if (a_to !== 1'b1 || a_led !== 2'b11) $display("FAIL to_flags: got to=%b led=%b want 1/11", a_to, a_led); else n_pass++;
      n_total++; if (a_dbg !== S_IDLE) $display("FAIL to_state: got %0d want 0", a_dbg); else n_pass++;
      n_total++; if (a_mtx !== 8'hD9 || a_stx !== 8'h25) $display("FAIL to_pat: got %h/%h want d9/25", a_mtx, a_stx); else n_pass++;
      withhold = 1'b0;
   endtask

   task automatic test_mode_sweep();
      logic [1:0] exp_mode [9];
      exp_mode = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wait_state(S_START, "sweep_start");
         n_total++;
         if ({a_cpol, a_cpha} !== exp_mode[i])
            $display("FAIL sweep_mode[%0d]: got %b%b want %b", i, a_cpol, a_cpha, exp_mode[i]);
         else n_pass++;
         n_total++;
         if ({b_cpol, b_cpha} !== 2'b00)
            $display("FAIL fixed_mode[%0d]: got %b%b want 00", i, b_cpol, b_cpha);
         else n_pass++;
         wait_xfer("sweep");
      end
      n_total++; if (a_pass !== 16'd9) $display("FAIL sweep_pass: got %0d want 9", a_pass); else n_pass++;
      n_total++; if (b_pass !== 16'd9 || b_err !== 16'd0) $display("FAIL fixed_counts: got %0d/%0d want 9/0", b_pass, b_err); else n_pass++;
   endtask

   task automatic test_saturation();
      wait_state(S_IDLE, "sat_idle");
      force dut.pass_count = 16'hFFFF;
      #1;
      release dut.pass_count;
      wait_xfer("sat");
      n_total++; if (a_pass !== 16'hFFFF) $display("FAIL sat_pass: got %h want ffff", a_pass); else n_pass++;
      n_total++; if (a_err !== 16'd0 || a_led !== 2'b00) $display("FAIL sat_other: got err=%0d led=%b want 0/00", a_err, a_led); else n_pass++;
   endtask

   task automatic test_clear();
      enable = 1'b0;
      wait_state(S_IDLE, "clr_idle");
      repeat (12) @(negedge clk);
      n_total++; if (a_cs !== 1'b1 || a_dbg !== S_IDLE) $display("FAIL hold_disabled: got cs=%b st=%0d want 1/0", a_cs, a_dbg); else n_pass++;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_total++; if (a_pass !== 16'd0 || a_err !== 16'd0) $display("FAIL clr_counts: got %0d/%0d want 0/0", a_pass, a_err); else n_pass++;
      n_total++; if (a_led !== 2'b11 || a_to !== 1'b0) $display("FAIL clr_flags: got led=%b to=%b want 11/0", a_led, a_to); else n_pass++;
      n_total++; if (a_mtx !== 8'h5A || a_stx !== 8'hC3) $display("FAIL clr_seed: got %h/%h want 5a/c3", a_mtx, a_stx); else n_pass++;
      enable = 1'b1;
      @(negedge clk);
      n_total++; if (a_cs !== 1'b0) $display("FAIL enable_start: got cs=%b want 0", a_cs); else n_pass++;
      // Clear in flight: the transfer completes, but its result is discarded.
      wait_state(S_WAIT, "clr_flight");
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      wait_xfer("clr_flight");
      n_total++; if (a_pass !== 16'd0 || a_err !== 16'd0 || a_led !== 2'b11) $display("FAIL clr_flight: got pass=%0d err=%0d led=%b want 0/0/11", a_pass, a_err, a_led); else n_pass++;
      n_total++; if (a_mtx !== 8'h5A || a_stx !== 8'hC3) $display("FAIL clr_flight_seed: got %h/%h want 5a/c3", a_mtx, a_stx); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_first_transfer();
      test_corrupt();
      test_timeout();
      test_mode_sweep();
      test_saturation();
      test_clear();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
